// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared byte width and transmit-feeder FSM state encoding
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// uart_sync_fifo : single-clock circular-buffer FIFO with registered status
// Rev 1.0
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  wr_ok;
  logic                  pop_ok;

  // A write against a full FIFO is dropped even if a pop frees a slot
  // on the same edge, so acceptance looks only at the registered flag.
  assign wr_ok  = wr_en && !full;
  assign pop_ok = pop && !empty;

  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_ok, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// uart_tx_feeder : byte FIFO draining into a UART transmitter via
// TXDATA/TXSTART/TXDONE. Optional sticky overflow flag: UART_TXFEED_OVF_EN.
// Rev 1.0
// ============================================================================
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [BYTE_W-1:0]   WRDATA,
  input  logic                WREN,
  output logic                FULL,
  output logic                EMPTY,
  output logic [DEPTH_LOG2:0] COUNT,
  output logic [BYTE_W-1:0]   TXDATA,
  output logic                TXSTART,
  input  logic                TXBUSY,
  input  logic                TXDONE,
  output logic                IDLE,
  output logic                OVERFLOW,
  input  logic                OVFCLR
);

  tx_state_t         state;
  tx_state_t         state_next;
  logic              pop;
  logic              start;
  logic [BYTE_W-1:0] head;

  uart_sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_data (WRDATA),
    .wr_en   (WREN),
    .pop     (pop),
    .rd_data (head),
    .full    (FULL),
    .empty   (EMPTY),
    .count   (COUNT)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TXDONE is only listened to in ST_WAIT; stray pulses elsewhere fall
  // through to the hold-state defaults.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!EMPTY && !TXBUSY) begin
          pop        = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_START;
      end
      ST_START: begin
        start      = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (TXDONE) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The launched byte is captured at pop time and held until the next pop,
  // so it stays stable for the whole transmission.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TXDATA <= '0;
    end else if (pop) begin
      TXDATA <= head;
    end
  end

  assign TXSTART = start;
  assign IDLE    = EMPTY && (state == ST_IDLE);

`ifdef UART_TXFEED_OVF_EN
  logic overflow_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_q <= 1'b0;
    end else if (WREN && FULL) begin
      overflow_q <= 1'b1;
    end else if (OVFCLR) begin
      overflow_q <= 1'b0;
    end
  end

  assign OVERFLOW = overflow_q;
`else
  logic unused_ovfclr;

  assign unused_ovfclr = OVFCLR;
  assign OVERFLOW      = 1'b0;
`endif

endmodule : uart_tx_feeder
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// Scoreboard bench for uart_tx_feeder: launched bytes are checked in order
// against a queue filled at write time; status outputs checked directly.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DL = 4;
`ifdef UART_TXFEED_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic          CLK    = 1'b0;
  logic          RESET  = 1'b1;
  logic [7:0]    WRDATA = 8'h00;
  logic          WREN   = 1'b0;
  logic          OVFCLR = 1'b0;
  logic          FULL, EMPTY, TXSTART, TXBUSY, TXDONE, IDLE, OVERFLOW;
  logic [DL:0]   COUNT;
  logic [7:0]    TXDATA;

  logic          hold   = 1'b0;
  logic          spur   = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_cnt  = 0;

  int            cyc = 0, checks = 0, errors = 0;
  int            starts = 0, start_cyc = 0, last_wr = 0, base = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    mon_exp;

  uart_tx_feeder #(.DEPTH_LOG2(DL)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .WRDATA   (WRDATA),
    .WREN     (WREN),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .TXDATA   (TXDATA),
    .TXSTART  (TXSTART),
    .TXBUSY   (TXBUSY),
    .TXDONE   (TXDONE),
    .IDLE     (IDLE),
    .OVERFLOW (OVERFLOW),
    .OVFCLR   (OVFCLR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign TXBUSY = m_busy | hold;
  assign TXDONE = m_done | spur;

  // Transmitter model: busy for a few cycles after TXSTART, then a DONE pulse.
  always @(posedge CLK) begin
    if (RESET) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (TXSTART) begin
        m_busy <= 1'b1;
        m_cnt  <= 3;
      end else if (m_busy && !hold) begin
        if (m_cnt == 0) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Monitor: every launch must match the oldest expected byte.
  always @(negedge CLK) begin
    if (TXSTART === 1'b1) begin
      starts++;
      start_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: TXDATA=%02h with nothing expected", TXDATA);
      end else begin
        mon_exp = exp_q.pop_front();
        if (TXDATA !== mon_exp) begin
          errors++;
          $display("FAIL launch_data: got %02h expected %02h", TXDATA, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit expect_out);
    WRDATA = b;
    WREN   = 1'b1;
    if (expect_out) exp_q.push_back(b);
    tick(1);
    last_wr = cyc;
    WREN    = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (starts >= target) break;
      tick(1);
    end
    if (starts < target) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got %0d starts expected %0d", starts, target);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && IDLE === 1'b1 && TXBUSY === 1'b0) break;
      tick(1);
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle state
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(5);
    @(negedge CLK);
    check("rst_empty",   EMPTY,   1);
    check("rst_full",    FULL,    0);
    check("rst_count",   COUNT,   0);
    check("rst_txstart", TXSTART, 0);
    check("rst_txdata",  TXDATA,  8'h00);
    check("rst_idle",    IDLE,    1);
    check("rst_ovf",     OVERFLOW, 0);
    @(posedge CLK); #1;

    // Single byte latency and completion
    base = starts;
    wr(8'hA5, 1'b1);
    wait_starts(base + 1, 12);
    check("a5_latency", start_cyc - last_wr, 2);
    begin : wait_done
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (TXDONE === 1'b1) disable wait_done;
      end
      checks++;
      errors++;
      $display("FAIL done_timeout: got no TXDONE expected a pulse");
    end
    @(negedge CLK);
    check("a5_idle_after_done", IDLE, 1);
    @(posedge CLK); #1;
    tick(4);
    check("a5_single_start", starts - base, 1);
    check("a5_txdata_held",  TXDATA, 8'hA5);

    // Burst of 16 with transmitter busy, dropped 17th write, wrap on drain
    hold = 1'b1;
    for (int i = 1; i <= 16; i++) wr(8'(i), 1'b1);
    @(negedge CLK);
    check("burst_full",  FULL,  1);
    check("burst_count", COUNT, 16);
    @(posedge CLK); #1;
    wr(8'hFF, 1'b0);
    @(negedge CLK);
    check("drop_count",    COUNT,    16);
    check("drop_full",     FULL,     1);
    check("drop_overflow", OVERFLOW, EXP_OVF);
    @(posedge CLK); #1;
    OVFCLR = 1'b1;
    tick(1);
    OVFCLR = 1'b0;
    @(negedge CLK);
    check("ovf_cleared", OVERFLOW, 0);
    @(posedge CLK); #1;
    hold = 1'b0;
    wait_drain("burst_drained", 400);

    // Simultaneous write and pop at COUNT=3
    hold = 1'b1;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    @(negedge CLK);
    check("simul_pre_count", COUNT, 3);
    @(posedge CLK); #1;
    hold = 1'b0;
    wr(8'h44, 1'b1);
    @(negedge CLK);
    check("simul_count", COUNT, 3);
    check("simul_busy",  IDLE,  0);
    @(posedge CLK); #1;
    wait_drain("simul_drained", 200);

    // Reset while waiting on the transmitter with four bytes queued
    base = starts;
    wr(8'h55, 1'b1);
    wait_starts(base + 1, 12);
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) wr(8'(8'h60 + i), 1'b0);
    @(negedge CLK);
    check("prerst_count", COUNT, 4);
    check("prerst_idle",  IDLE,  0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    tick(1);
    @(negedge CLK);
    check("midrst_count",  COUNT,  0);
    check("midrst_empty",  EMPTY,  1);
    check("midrst_idle",   IDLE,   1);
    check("midrst_txdata", TXDATA, 8'h00);
    @(posedge CLK); #1;
    RESET = 1'b0;
    hold  = 1'b0;
    base  = starts;
    tick(20);
    check("postrst_no_start", starts - base, 0);

    // Spurious TXDONE while idle and empty
    base = starts;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    @(negedge CLK);
    check("spur_idle",   IDLE,   1);
    check("spur_empty",  EMPTY,  1);
    check("spur_txdata", TXDATA, 8'h00);
    @(posedge CLK); #1;
    tick(5);
    check("spur_no_start", starts - base, 0);
    check("final_queue",   exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_feeder
`default_nettype wire

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering stage directly upstream of the UART transmitter top. It accepts bytes from the system side into a synchronous FIFO and drains them one at a time into the transmitter. It launches each byte with the TXDATA/TXSTART handshake and waits for TXDONE before launching the next. System logic can queue bursts without tracking the transmitter's busy state.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes (16); legal range 1..8.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- WRDATA  in  8  byte to enqueue.
- WREN  in  1  enqueue strobe; sampled every cycle.
- FULL  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- EMPTY  out  1  FIFO holds 0 bytes.
- COUNT  out  DEPTH_LOG2+1  bytes currently stored. Excludes the byte in flight.
- TXDATA  out  8  byte presented to the transmitter.
- TXSTART  out  1  one-cycle launch pulse to the transmitter.
- TXBUSY  in  1  transmitter busy, from the transmitter.
- TXDONE  in  1  one-cycle completion pulse, from the transmitter.
- IDLE  out  1  EMPTY and FSM in ST_IDLE.
- OVERFLOW  out  1  sticky write-while-full flag; see Configuration.
- OVFCLR  in  1  clears OVERFLOW.

## Operation
- FIFO behaviour:
  - Circular buffer with read and write pointers of DEPTH_LOG2 bits, wrapping modulo 2**DEPTH_LOG2.
  - COUNT is DEPTH_LOG2+1 bits.
  - A write is accepted when WREN=1 and FULL=0. A write with FULL=1 is dropped, even if a pop happens in the same cycle.
  - A pop is requested only by the FSM in ST_IDLE when EMPTY=0.
  - Simultaneous accepted write and pop leave COUNT unchanged.
- FSM states, encoded 2 bits:
  - ST_IDLE: if EMPTY=0 and TXBUSY=0, pop the head byte into the TXDATA register and go to ST_LOAD. Otherwise stay.
  - ST_LOAD: go to ST_START. TXDATA is stable.
  - ST_START: TXSTART=1 for exactly this cycle, then go to ST_WAIT.
  - ST_WAIT: on TXDONE=1 go to ST_IDLE. Otherwise stay; there is no timeout.
- TXDATA holds its value from ST_LOAD until the next pop. It never changes while the transmitter is busy.
- TXDONE outside ST_WAIT is ignored.
- Reset values, applied on RESET=1 at a clock edge:
  - FIFO flushed, pointers 0, COUNT=0, EMPTY=1, FULL=0.
  - TXDATA=8'h00, TXSTART=0, FSM=ST_IDLE, IDLE=1, OVERFLOW=0.
- Reset mid-transfer discards both the queued bytes and the in-flight byte. The transmitter shares RESET and aborts too.

## Timing
- FULL, EMPTY and COUNT are registered and reflect the writes and pops of the previous edge.
- Latency from an empty, idle block with TXBUSY=0:
  - WREN sampled at edge 0.
  - EMPTY=0 after edge 0.
  - Pop at edge 1.
  - TXSTART high between edges 2 and 3.
  - Two cycles from write edge to TXSTART.
- Back-to-back bytes:
  - The next pop occurs at the edge after TXDONE is sampled.
  - Gap from TXDONE to the next TXSTART: 3 cycles.
- TXSTART is never asserted while TXBUSY=1 is sampled in ST_IDLE.

## Configuration
- UART_TXFEED_OVF_EN defined:
  - OVERFLOW sets on any cycle with WREN=1 and FULL=1.
  - OVERFLOW clears on OVFCLR=1 without a simultaneous overflow; set wins over clear.
- UART_TXFEED_OVF_EN undefined:
  - OVERFLOW is tied to 0 and OVFCLR is ignored.
  - Dropped writes are silent.

## Structure
- Shared package `uart_pkg`:
  - byte width constant (8).
  - FSM state constants ST_IDLE, ST_LOAD, ST_START, ST_WAIT.
- One sub-module, `uart_sync_fifo`:
  - generic single-clock FIFO, parameterised by width and DEPTH_LOG2.
  - ports for write, pop, FULL, EMPTY, COUNT.
- The FSM and overflow logic live in the top.

## Test plan
- Reset, then 5 idle cycles: EMPTY=1, FULL=0, COUNT=0, TXSTART=0, TXDATA=8'h00, IDLE=1.
- Write 8'hA5 with TXBUSY=0: TXSTART pulses exactly once, 2 cycles after the write edge, with TXDATA=8'hA5. IDLE returns 1 one cycle after TXDONE.
- Write 8'h01..8'h10 back-to-back (16 bytes) with the transmitter model held busy:
  - FULL=1 and COUNT=16 after the last write.
  - A 17th write, 8'hFF, is dropped.
  - OVERFLOW=1 only with UART_TXFEED_OVF_EN.
  - Output order is 01..10, covering pointer wrap.
- Simultaneous write and pop with COUNT=3: COUNT stays 3. The bytes leave in FIFO order.
- RESET asserted in ST_WAIT with COUNT=4: next cycle COUNT=0, FSM=ST_IDLE, no further TXSTART without new writes.
- Spurious TXDONE pulse in ST_IDLE with EMPTY=1: no state change, no TXSTART.
